// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between IF and DM, DM-first with IF anti-starvation
module mem_port_arbiter #(
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_valid,
  output logic [31:0] o_if_rdata,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic        i_dm_byte,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic        o_dm_gnt,
  output logic        o_dm_valid,
  output logic [31:0] o_dm_rdata,
  output logic        o_stall_if,
  output logic        o_stall_dm,
  output logic        o_mem_en,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;
  localparam logic [3:0] LAT      = 4'(MEM_LATENCY);
  localparam logic [3:0] LIM      = 4'(STARVE_LIMIT);
  logic [1:0]  r_state;
  logic [3:0]  r_lat_cnt;
  logic [3:0]  r_starve_cnt;
  logic        r_we;
  logic        r_byte;
  logic [1:0]  r_boff;
  logic        r_if_valid;
  logic        r_dm_valid;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        w_idle;
  logic        w_force_if;
  logic        w_gnt_if;
  logic        w_gnt_dm;
  logic        w_done;
  logic [7:0]  w_byte;
  logic [31:0] w_load;
  logic        w_unused;
  // grants are combinational and suppressed while reset is asserted so every output reads 0
  assign w_idle     = i_reset_n && r_state == S_IDLE;
  assign w_force_if = r_starve_cnt == LIM;
  assign w_gnt_dm   = w_idle && i_dm_req && !(w_force_if && i_if_req);
  assign w_gnt_if   = w_idle && i_if_req && !w_gnt_dm;
  assign w_done     = r_state != S_IDLE && r_lat_cnt == 4'd1;
  assign w_unused   = ^i_if_addr[1:0];
  assign o_if_gnt    = w_gnt_if;
  assign o_dm_gnt    = w_gnt_dm;
  assign o_mem_en    = w_gnt_if | w_gnt_dm;
  assign o_mem_we    = w_gnt_dm & i_dm_we;
  assign o_mem_addr  = w_gnt_dm ? {i_dm_addr[31:2], 2'b00} : w_gnt_if ? {i_if_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_wdata = o_mem_we ? i_dm_wdata : 32'h0;
  assign o_if_valid  = r_if_valid;
  assign o_dm_valid  = r_dm_valid;
  assign o_if_rdata  = r_if_rdata;
  assign o_dm_rdata  = r_dm_rdata;
  assign o_stall_if  = i_reset_n & i_if_req & ~r_if_valid;
  assign o_stall_dm  = i_reset_n & i_dm_req & ~r_dm_valid;
  // big-endian byte lane select, then sign extension for LB
  assign w_byte = r_boff == 2'd0 ? i_mem_rdata[31:24] : r_boff == 2'd1 ? i_mem_rdata[23:16] :
                  r_boff == 2'd2 ? i_mem_rdata[15:8] : i_mem_rdata[7:0];
  assign w_load = r_byte ? {{24{w_byte[7]}}, w_byte} : i_mem_rdata;
  // access FSM: a grant loads the latency counter, the last count returns to IDLE
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
    end else if (w_gnt_dm || w_gnt_if) begin
      r_state   <= w_gnt_dm ? S_BUSY_D : S_BUSY_I;
      r_lat_cnt <= LAT;
    end else if (w_done) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 4'd0;
    end else if (r_state != S_IDLE) begin
      r_lat_cnt <= r_lat_cnt - 4'd1;
    end
  end
  // capture the DM access kind and byte offset needed when its data returns
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we   <= 1'b0;
      r_byte <= 1'b0;
      r_boff <= 2'd0;
    end else if (w_gnt_dm) begin
      r_we   <= i_dm_we;
      r_byte <= i_dm_byte & ~i_dm_we;
      r_boff <= i_dm_addr[1:0];
    end
  end
  // count DM wins over a waiting IF; reaching the limit hands the next grant to IF
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_starve_cnt <= 4'd0;
    else if (!i_if_req || w_gnt_if) r_starve_cnt <= 4'd0;
    else if (w_gnt_dm && r_starve_cnt < LIM) r_starve_cnt <= r_starve_cnt + 4'd1;
  end
  // register returning data on the last latency cycle and pulse the matching valid next cycle
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      r_if_rdata <= 32'h0;
      r_dm_rdata <= 32'h0;
    end else begin
      r_if_valid <= w_done && r_state == S_BUSY_I;
      r_dm_valid <= w_done && r_state == S_BUSY_D;
      if (w_done && r_state == S_BUSY_I) r_if_rdata <= i_mem_rdata;
      if (w_done && r_state == S_BUSY_D && !r_we) r_dm_rdata <= w_load;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with access and read-data scoreboards checked by a negedge monitor
module tb_mem_port_arbiter;
  localparam int L = 2;
  typedef struct packed {logic dm; logic we; logic [31:0] addr; logic [31:0] wdata;} acc_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, dm_byte = 1'b0;
  logic [31:0] if_addr = 32'h0, dm_addr = 32'h0, dm_wdata = 32'h0;
  logic if_gnt, if_valid, dm_gnt, dm_valid, stall_if, stall_dm, mem_en, mem_we;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, failures = 0, cyc = 0;
  acc_t q_acc[$];
  acc_t e_acc;
  logic [31:0] q_if[$], q_dm[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] rdq[L];
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_LIMIT(4)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt), .o_if_valid(if_valid), .o_if_rdata(if_rdata),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_byte(dm_byte), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_gnt(dm_gnt), .o_dm_valid(dm_valid), .o_dm_rdata(dm_rdata),
    .o_stall_if(stall_if), .o_stall_dm(stall_dm),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata));
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a ^ 32'hA5A50000;
  endfunction
  // memory model: data for an access appears exactly L cycles after mem_en, garbage otherwise
  always @(posedge clk) begin
    cyc++;
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    rdq[0] <= mem_en ? rd(mem_addr) : 32'hBAD0BAD0;
    for (int i = 1; i < L; i++) rdq[i] <= rdq[i-1];
  end
  assign mem_rdata = rdq[L-1];
  task automatic chk(input string n, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        chk("access expected", q_acc.size() > 0, 1);
        if (q_acc.size() > 0) begin
          e_acc = q_acc.pop_front();
          chk("access fields", {dm_gnt, mem_we, mem_addr, mem_wdata}, e_acc);
          chk("grant onehot", if_gnt ^ dm_gnt, 1);
        end
      end
      if (if_valid) begin
        chk("if_valid expected", q_if.size() > 0, 1);
        if (q_if.size() > 0) chk("if_rdata", if_rdata, q_if.pop_front());
      end
      if (dm_valid) begin
        chk("dm_valid expected", q_dm.size() > 0, 1);
        if (q_dm.size() > 0) chk("dm_rdata", dm_rdata, q_dm.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic dm_access(input logic we, input logic byt, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp, input string n);
    int g, v;
    q_acc.push_back({1'b1, we, addr[31:2], 2'b00, we ? wdata : 32'h0});
    q_dm.push_back(exp);
    dm_req = 1'b1; dm_we = we; dm_byte = byt; dm_addr = addr; dm_wdata = wdata;
    g = -1;
    for (int i = 0; i < 20 && g < 0; i++) begin
      @(negedge clk);
      if (dm_gnt) g = cyc;
    end
    tick();
    dm_req = 1'b0;
    v = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      @(negedge clk);
      if (dm_valid) v = cyc;
    end
    chk({n, " latency"}, 66'(v - g), L + 1);
    tick();
  endtask
  initial begin
    int g, v;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int g, v;
    mem[32'h400] = 32'h12F45678;
    @(negedge clk);
    chk("reset outputs", |{if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, stall_if, stall_dm,
                           mem_en, mem_we, mem_addr, mem_wdata}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("idle mem_en", mem_en, 0);
    tick();
    q_acc.push_back({1'b0, 1'b0, 32'h100, 32'h0});
    q_if.push_back(32'hA5A50100);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk("t1 if_gnt", if_gnt, 1);
    chk("t1 stall_if", stall_if, 1);
    g = cyc;
    tick();
    if_req = 1'b0;
    v = -1;
    for (int i = 0; i < 20 && v < 0; i++) begin
      @(negedge clk);
      if (if_valid) v = cyc;
    end
    chk("t1 latency", 66'(v - g), L + 1);
    tick();
    q_acc.push_back({1'b1, 1'b0, 32'h208, 32'h0});
    q_acc.push_back({1'b0, 1'b0, 32'h104, 32'h0});
    q_acc.push_back({1'b0, 1'b0, 32'h104, 32'h0});
    q_dm.push_back(32'hA5A50208);
    q_if.push_back(32'hA5A50104);
    q_if.push_back(32'hA5A50104);
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h208;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("t2 dm_gnt k%0d", k), dm_gnt, k == 0);
      chk($sformatf("t2 if_gnt k%0d", k), if_gnt, k == 3 || k == 6);
      chk($sformatf("t2 dm_valid k%0d", k), dm_valid, k == 3);
      chk($sformatf("t2 if_valid k%0d", k), if_valid, k == 6);
      chk($sformatf("t2 stall_if k%0d", k), stall_if, k != 6);
      tick();
      if (k == 0) dm_req = 1'b0;
      if (k == 6) if_req = 1'b0;
    end
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      q_acc.push_back({1'b1, 1'b0, 32'h300, 32'h0});
      q_dm.push_back(32'hA5A50300);
    end
    q_acc.push_back({1'b0, 1'b0, 32'h108, 32'h0});
    q_if.push_back(32'hA5A50108);
    if_req = 1'b1; if_addr = 32'h108;
    dm_req = 1'b1; dm_addr = 32'h300;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("t3 dm_gnt k%0d", k), dm_gnt, k % 3 == 0 && k < 12);
      chk($sformatf("t3 if_gnt k%0d", k), if_gnt, k == 12);
      tick();
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (4) tick();
    dm_access(1'b0, 1'b0, 32'h401, 32'h0, 32'h12F45678, "t4 word");
    dm_access(1'b0, 1'b1, 32'h401, 32'h0, 32'hFFFFFFF4, "t4 lb1");
    dm_access(1'b0, 1'b1, 32'h400, 32'h0, 32'h00000012, "t4 lb0");
    dm_access(1'b0, 1'b1, 32'h402, 32'h0, 32'h00000056, "t4 lb2");
    dm_access(1'b0, 1'b1, 32'h403, 32'h0, 32'h00000078, "t4 lb3");
    dm_access(1'b1, 1'b0, 32'h203, 32'hDEADBEEF, 32'h00000078, "t5 store");
    dm_access(1'b0, 1'b0, 32'h200, 32'h0, 32'hDEADBEEF, "t5 readback");
    q_acc.push_back({1'b1, 1'b0, 32'h500, 32'h0});
    dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 32'h500;
    @(negedge clk);
    chk("t6 dm_gnt", dm_gnt, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6 reset outputs", |{if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_rdata, stall_if, stall_dm,
                              mem_en, mem_we, mem_addr, mem_wdata}, 0);
    dm_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6 dm_rdata cleared", dm_rdata, 0);
    dm_access(1'b0, 1'b0, 32'h504, 32'h0, 32'hA5A50504, "t6 after reset");
    repeat (3) tick();
    chk("access queue drained", q_acc.size(), 0);
    chk("if queue drained", q_if.size(), 0);
    chk("dm queue drained", q_dm.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
